// File: rtl/room_model.sv
// Thermal plant model: the heater/cooler command registers into a plant mode, and the
// room temperature moves one degree per step tick (HEAT/COOL) or drifts toward ambient (IDLE).
// Optional random disturbance is enabled with macro ROOM_MODEL_DISTURB_EN.
module room_model #(
    parameter logic [4:0]  INIT_TEMP   = 5'd20,
    parameter int unsigned STEP_PERIOD = 8,
    parameter int unsigned DRIFT_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       heating,
    input  logic       cooling,
    input  logic [4:0] ambient,
    output logic [4:0] temperature,
    output logic [1:0] mode,
    output logic       fault,
    output logic       at_limit
);

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_HEAT  = 2'b01,
        MODE_COOL  = 2'b10,
        MODE_FAULT = 2'b11
    } mode_e;

    localparam logic [7:0] STEP_LAST  = 8'(STEP_PERIOD - 1);
    localparam logic [3:0] DRIFT_LAST = 4'(DRIFT_DIV - 1);

    mode_e       mode_q, mode_d;
    logic [7:0]  step_cnt_q, step_cnt_d;
    logic [3:0]  drift_cnt_q, drift_cnt_d;
    logic [4:0]  temperature_q, temperature_d;
    logic        tick;
    logic        disturb;
    logic signed [2:0] base_step;
    logic signed [2:0] net_step;
    logic [6:0]  temp_sum;

    assign tick = (step_cnt_q == STEP_LAST);

    always_comb begin
        mode_d     = mode_e'({cooling, heating});
        step_cnt_d = tick ? 8'd0 : step_cnt_q + 8'd1;
    end

`ifdef ROOM_MODEL_DISTURB_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci form of x^8+x^6+x^5+x^4+1; the pre-advance value decides the disturbance.
    always_comb begin
        lfsr_d  = lfsr_q;
        disturb = 1'b0;
        if (tick) begin
            lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            disturb = (mode_q != MODE_FAULT) && (lfsr_q[2:0] == 3'b000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign disturb = 1'b0;
`endif

    // Drift only accumulates across consecutive IDLE ticks; any other mode restarts it.
    always_comb begin
        base_step   = 3'sd0;
        drift_cnt_d = drift_cnt_q;
        if (mode_q != MODE_IDLE) begin
            drift_cnt_d = 4'd0;
        end else if (tick) begin
            if (drift_cnt_q == DRIFT_LAST) begin
                drift_cnt_d = 4'd0;
                if (ambient > temperature_q) begin
                    base_step = 3'sd1;
                end else if (ambient < temperature_q) begin
                    base_step = -3'sd1;
                end
            end else begin
                drift_cnt_d = drift_cnt_q + 4'd1;
            end
        end
        if (tick && mode_q == MODE_HEAT) begin
            base_step = 3'sd1;
        end
        if (tick && mode_q == MODE_COOL) begin
            base_step = -3'sd1;
        end
    end

    // Net step is -1..+2; bit 6 flags an underflow, bit 5 an overflow past 31.
    always_comb begin
        net_step = base_step + $signed({2'b00, disturb});
        temp_sum = {2'b00, temperature_q} + {{4{net_step[2]}}, net_step};
        if (temp_sum[6]) begin
            temperature_d = 5'd0;
        end else if (temp_sum[5]) begin
            temperature_d = 5'd31;
        end else begin
            temperature_d = temp_sum[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MODE_IDLE;
            step_cnt_q    <= 8'd0;
            drift_cnt_q   <= 4'd0;
            temperature_q <= INIT_TEMP;
        end else begin
            mode_q        <= mode_d;
            step_cnt_q    <= step_cnt_d;
            drift_cnt_q   <= drift_cnt_d;
            temperature_q <= temperature_d;
        end
    end

    assign temperature = temperature_q;
    assign mode        = mode_q;
    assign fault       = (mode_q == MODE_FAULT);
    assign at_limit    = (temperature_q == 5'd0) || (temperature_q == 5'd31);

endmodule

// File: tb/tb_room_model.sv
// Bench for room_model: constant vector table, reset/tick corner sequence, and a long
// random run checked every cycle against a tick-counting reference model.
module tb_room_model;

    localparam int SP   = 4;
    localparam int DD   = 2;
    localparam int INIT = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       heating;
    logic       cooling;
    logic [4:0] ambient;
    logic [4:0] temperature;
    logic [1:0] mode;
    logic       fault;
    logic       at_limit;

    int n_checks = 0;
    int n_errors = 0;

    room_model #(
        .INIT_TEMP  (5'd20),
        .STEP_PERIOD(SP),
        .DRIFT_DIV  (DD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .heating    (heating),
        .cooling    (cooling),
        .ambient    (ambient),
        .temperature(temperature),
        .mode       (mode),
        .fault      (fault),
        .at_limit   (at_limit)
    );

    always #5 clk = ~clk;

    // Reference model: cycles since reset, ticks seen while idle, plain integer temperature.
    int         m_temp;
    int         m_mode;
    int         m_phase;
    int         m_idle;
    logic [7:0] m_lfsr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int  delta;
        bit  tk;
        if (rst) begin
            m_temp  = INIT;
            m_mode  = 0;
            m_phase = 0;
            m_idle  = 0;
            m_lfsr  = 8'hA5;
            return;
        end
        tk    = (m_phase == SP - 1);
        delta = 0;
        if (m_mode != 0) begin
            m_idle = 0;
        end else if (tk) begin
            m_idle++;
            if (m_idle % DD == 0) begin
                if (int'(ambient) > m_temp) delta = 1;
                else if (int'(ambient) < m_temp) delta = -1;
            end
        end
        if (tk && m_mode == 1) delta = 1;
        if (tk && m_mode == 2) delta = -1;
`ifdef ROOM_MODEL_DISTURB_EN
        if (tk) begin
            if (m_mode != 3 && m_lfsr[2:0] == 3'b000) delta++;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
`endif
        m_temp = m_temp + delta;
        if (m_temp < 0) m_temp = 0;
        if (m_temp > 31) m_temp = 31;
        m_phase = (m_phase + 1) % SP;
        m_mode  = {30'd0, cooling, heating};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            model_update();
            @(posedge clk);
            #1;
            chk("model_temp",  32'(temperature), 32'(m_temp));
            chk("model_mode",  32'(mode),        32'(m_mode));
            chk("model_fault", 32'(fault),       32'(m_mode == 3));
            chk("model_limit", 32'(at_limit),    32'(m_temp == 0 || m_temp == 31));
        end
    endtask

    typedef struct {
        logic       rst;
        logic       heat;
        logic       cool;
        logic [4:0] amb;
        int         ncyc;
        logic [4:0] temp;
        logic [1:0] mode;
        logic       fault;
        logic       lim;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst     = 1'b1;
        heating = 1'b0;
        cooling = 1'b0;
        ambient = 5'd20;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd20,   3, 5'd20, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd20,  40, 5'd30, 2'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd20,   8, 5'd31, 2'd1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 5'd20,   8, 5'd31, 2'd3, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd20,   4, 5'd30, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd20,  20, 5'd25, 2'd2, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd10,   1, 5'd25, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd10, 120, 5'd10, 2'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 5'd12,  40, 5'd12, 2'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 5'd12,   1, 5'd20, 2'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd12, 100, 5'd0,  2'd2, 1'b0, 1'b1};

`ifndef ROOM_MODEL_DISTURB_EN
        for (int v = 0; v < 11; v++) begin
            rst     = vecs[v].rst;
            heating = vecs[v].heat;
            cooling = vecs[v].cool;
            ambient = vecs[v].amb;
            run(vecs[v].ncyc);
            chk($sformatf("vec%0d_temp", v),  32'(temperature), 32'(vecs[v].temp));
            chk($sformatf("vec%0d_mode", v),  32'(mode),        32'(vecs[v].mode));
            chk($sformatf("vec%0d_fault", v), 32'(fault),       32'(vecs[v].fault));
            chk($sformatf("vec%0d_limit", v), 32'(at_limit),    32'(vecs[v].lim));
        end

        // Reset landing on a tick cycle mid-ramp, then the first tick after release.
        rst = 1'b1; heating = 1'b0; cooling = 1'b0; ambient = 5'd20;
        run(1);
        rst = 1'b0; cooling = 1'b1;
        run(23);
        chk("ramp_to_15", 32'(temperature), 32'd15);
        rst = 1'b1;
        run(1);
        chk("rst_on_tick_temp", 32'(temperature), 32'd20);
        chk("rst_on_tick_mode", 32'(mode),        32'd0);
        rst = 1'b0; cooling = 1'b0; heating = 1'b1;
        run(3);
        chk("pre_first_tick", 32'(temperature), 32'd20);
        chk("heat_mode",      32'(mode),        32'd1);
        run(1);
        chk("first_tick",     32'(temperature), 32'd21);
`else
        rst = 1'b1;
        run(3);
        rst = 1'b0; ambient = 5'd20;
        run(256 * SP);
`endif

        rst = 1'b1; heating = 1'b0; cooling = 1'b0;
        run(2);
        rst = 1'b0;
        for (int r = 0; r < 300; r++) begin
            int sel;
            sel     = int'($urandom_range(0, 9));
            heating = (sel <= 3) || (sel == 9);
            cooling = (sel >= 4 && sel <= 6) || (sel == 9);
            ambient = 5'($urandom_range(0, 31));
            rst     = ($urandom_range(0, 49) == 0);
            run(int'($urandom_range(1, 40)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/room_model.md
ROOM_MODEL -- requirements
Module: room_model

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter INIT_TEMP, default 5'd20: temperature loaded on reset.
REQ-003 Parameter STEP_PERIOD, default 8: clock cycles per thermal step tick; legal range 2..255.
REQ-004 Parameter DRIFT_DIV, default 4: step ticks per ambient-drift step; legal range 1..15.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 heating  input  1  heater command from the air-conditioning controller.
REQ-008 cooling  input  1  cooler command from the air-conditioning controller.
REQ-009 ambient  input  5  outside temperature, unsigned degrees 0..31.
REQ-010 temperature  output  5  modelled room temperature, registered, unsigned 0..31.
REQ-011 mode  output  2  registered plant mode: 00 IDLE, 01 HEAT, 10 COOL, 11 FAULT.
REQ-012 fault  output  1  high while mode==FAULT.
REQ-013 at_limit  output  1  high while temperature==0 or temperature==31.

Function
REQ-014 mode SHALL register {cooling,heating} every cycle: 00->IDLE, 01->HEAT, 10->COOL, 11->FAULT; command-to-mode latency is 1 cycle.
REQ-015 A free-running step counter SHALL count 0..STEP_PERIOD-1 and wrap to 0; tick is high in the cycle where count==STEP_PERIOD-1.
REQ-016 Mode changes SHALL NOT reset the step counter.
REQ-017 On a tick in HEAT, temperature SHALL increment by 1, saturating at 31.
REQ-018 On a tick in COOL, temperature SHALL decrement by 1, saturating at 0.
REQ-019 In FAULT, temperature SHALL hold regardless of tick.
REQ-020 In IDLE, a drift counter SHALL advance on each tick; on every DRIFT_DIV-th tick, temperature SHALL move 1 toward ambient, or hold if equal.
REQ-021 The drift counter SHALL clear whenever mode is not IDLE.
REQ-022 ambient SHALL be sampled only in the tick cycle; changes between ticks have no effect.
REQ-023 Temperature SHALL change on the clock edge that ends the tick cycle, with at most one net step of ±1 per tick.
REQ-024 fault and at_limit SHALL be decoded combinationally from the registered mode and temperature; they SHALL NOT add latency.

Reset
REQ-025 While rst is high: temperature=INIT_TEMP, mode=00, fault=0, at_limit=0 for the default INIT_TEMP, and the step and drift counters are 0.
REQ-026 rst asserted mid-operation SHALL override every update in the same cycle, and SHALL take priority over any tick.
REQ-027 After rst falls, the first tick SHALL occur STEP_PERIOD cycles later.

Configuration
REQ-028 With macro ROOM_MODEL_DISTURB_EN defined, an 8-bit LFSR SHALL be present and behave as follows:
- polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances once per tick;
- on a tick in IDLE, HEAT or COOL where lfsr[2:0]==3'b000, a disturbance of +1 SHALL add to that tick's step (net change -1..+2), with the result saturating at 31.
REQ-029 Without ROOM_MODEL_DISTURB_EN, no LFSR SHALL be synthesised, and behaviour SHALL be exactly as REQ-017..REQ-023.

Verification (STEP_PERIOD=4, DRIFT_DIV=2, INIT_TEMP=20, macro undefined unless stated)
REQ-030 rst high for 3 cycles, then low -> temperature=20, mode=00, fault=0, at_limit=0; first tick 4 cycles after rst falls.
REQ-031 heating=1 held for 40 cycles -> temperature +1 every 4 cycles, 20->30 after 10 ticks; hold 8 more cycles -> 31, then stays at 31 with at_limit=1.
REQ-032 heating=1 and cooling=1 -> mode=11 and fault=1 one cycle later, temperature frozen across ticks; drop cooling -> mode=01 next cycle, and the ramp resumes.
REQ-033 IDLE with ambient=10 from temperature 20 -> temperature -1 every 8 cycles; reaches 10 after 80 cycles, then holds; change ambient to 12 -> +1 per 8 cycles, stops at 12.
REQ-034 cooling=1 ramping and temperature=15, rst pulsed 1 cycle -> temperature=20, mode=00 on the next edge; counters restart, and the first tick arrives 4 cycles later.
REQ-035 Macro defined, IDLE with ambient=temperature=20 for 256 ticks -> temperature rises only on ticks where the LFSR (seed A5) gives lfsr[2:0]==0, and matches the reference model bit-exactly.
